// File: rtl/control_juego_pkg.sv
// Shared game types and constants: FSM state encoding, level codes and the
// default timing thresholds used by the display and enemy blocks.
package juego_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAYING,
    PAUSED,
    HIT_WAIT,
    WIN,
    GAME_OVER
  } estado_t;

  localparam logic [1:0] NIVEL_0 = 2'd0;
  localparam logic [1:0] NIVEL_1 = 2'd1;
  localparam logic [1:0] NIVEL_2 = 2'd2;
  localparam logic [1:0] NIVEL_3 = 2'd3;

  localparam int CLK_HZ_DEF    = 27000000;
  localparam int T_NIVEL2_DEF  = 60;
  localparam int T_NIVEL3_DEF  = 135;
  localparam int T_WIN_DEF     = 225;
  localparam int VIDAS_INI_DEF = 3;
  localparam int INV_SEG_DEF   = 2;

endpackage

// File: rtl/control_juego_divisor_tick.sv
// Game-second prescaler: counts enabled clk cycles and emits a registered
// one-cycle tick on each wrap; the count is held while en is low.
module divisor_tick
  import juego_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == CW'(CLK_HZ - 1)) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/control_juego.sv
// Round sequencer for the hero game: run/pause/hit/win/lose flow, elapsed
// seconds, difficulty level, lives and post-hit invulnerability.
module control_juego
  import juego_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int T_NIVEL2  = T_NIVEL2_DEF,
  parameter int T_NIVEL3  = T_NIVEL3_DEF,
  parameter int T_WIN     = T_WIN_DEF,
  parameter int VIDAS_INI = VIDAS_INI_DEF,
  parameter int INV_SEG   = INV_SEG_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pausa,
  input  logic       golpe,
  output logic       jugando,
  output logic [7:0] segundos,
  output logic [1:0] nivel,
  output logic [1:0] vidas,
  output logic       tick_1s,
  output logic       nivel_up,
  output logic       win,
  output logic       game_over
);

  estado_t    estado;
  logic       tick;
  logic       en_div;
  logic       cuenta;
  logic       llega_win;
  logic [7:0] inv;
  logic [7:0] seg_sig;
  logic [1:0] nivel_sig;

  function automatic logic [1:0] nivel_de(input logic [7:0] s);
    if (s < 8'(T_NIVEL2)) return NIVEL_1;
    else if (s < 8'(T_NIVEL3)) return NIVEL_2;
    return NIVEL_3;
  endfunction

  assign en_div    = (estado == PLAYING) || (estado == HIT_WAIT);
  assign seg_sig   = segundos + 8'd1;
  assign nivel_sig = nivel_de(seg_sig);
  // A tick registered on the very edge that entered PAUSED is still a counted second.
  assign cuenta    = tick && (en_div || (estado == PAUSED));
  assign llega_win = cuenta && (seg_sig == 8'(T_WIN));
  assign tick_1s   = tick;

  divisor_tick #(.CLK_HZ(CLK_HZ)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en_div),
    .clr  (start),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= IDLE;
      segundos  <= 8'd0;
      nivel     <= NIVEL_0;
      vidas     <= 2'(VIDAS_INI);
      inv       <= 8'd0;
      jugando   <= 1'b0;
      nivel_up  <= 1'b0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      nivel_up <= 1'b0;
      if (start) begin
        estado    <= PLAYING;
        segundos  <= 8'd0;
        nivel     <= NIVEL_1;
        vidas     <= 2'(VIDAS_INI);
        inv       <= 8'd0;
        jugando   <= 1'b1;
        win       <= 1'b0;
        game_over <= 1'b0;
      end else if (llega_win) begin
        segundos <= seg_sig;
        nivel    <= nivel_sig;
        nivel_up <= (nivel_sig != nivel);
        estado   <= WIN;
        jugando  <= 1'b0;
        win      <= 1'b1;
      end else begin
        if (cuenta) begin
          segundos <= seg_sig;
          nivel    <= nivel_sig;
          nivel_up <= (nivel_sig != nivel);
        end
        // Hit outranks pause; HIT_WAIT and PAUSED are deaf to golpe.
        unique case (estado)
          PLAYING: begin
            if (golpe) begin
              if (vidas == 2'd1) begin
                vidas     <= 2'd0;
                estado    <= GAME_OVER;
                jugando   <= 1'b0;
                game_over <= 1'b1;
              end else begin
                vidas  <= vidas - 2'd1;
                inv    <= 8'(INV_SEG);
                estado <= HIT_WAIT;
              end
            end else if (pausa) begin
              estado  <= PAUSED;
              jugando <= 1'b0;
            end
          end
          HIT_WAIT: begin
            if (tick) begin
              inv <= inv - 8'd1;
              if (inv == 8'd1) estado <= PLAYING;
            end
          end
          PAUSED: begin
            if (pausa) begin
              estado  <= PLAYING;
              jugando <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
